// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM that owns the PC.
// Define CORE_PERF_CNT_EN to add the cycle_cnt / retire_cnt performance counters.
module core_sequencer #(
  parameter int unsigned         LEN_WORD = 32,
  parameter logic [LEN_WORD-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [LEN_WORD-1:0] pc,
  output logic                imem_req,
  input  logic                imem_valid,
  output logic                inst_we,
  input  logic                dec_alu,
  input  logic                dec_mem,
  input  logic                dec_mem_store,
  input  logic                dec_jump,
  input  logic                dec_branch,
  input  logic                dec_subst,
  input  logic                br_taken,
  input  logic [LEN_WORD-1:0] jump_target,
  input  logic [LEN_WORD-1:0] branch_target,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_done,
  output logic                rf_we,
  output logic                halted,
  output logic [2:0]          state
`ifdef CORE_PERF_CNT_EN
  ,
  output logic [63:0]         cycle_cnt,
  output logic [63:0]         retire_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [LEN_WORD-1:0] pc_q;
  logic                any_class;
  logic                wb_writes_rf;

  assign any_class    = dec_alu | dec_mem | dec_jump | dec_branch | dec_subst;
  assign wb_writes_rf = dec_alu | dec_subst | dec_jump | (dec_mem & ~dec_mem_store);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Encodings 5/6 fall into the default arm and are trapped in HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem_valid) state_d = S_DECODE;
      S_DECODE: state_d = any_class ? S_EXEC : S_HALT;
      S_EXEC:   state_d = dec_mem ? S_MEM : S_WB;
      S_MEM:    if (dmem_done) state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    inst_we  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        inst_we  = imem_valid;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_store;
      end
      S_WB:    rf_we  = wb_writes_rf;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // Jump wins over a taken branch when both class flags are raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (state_q == S_WB) begin
      if (dec_jump) begin
        pc_q <= jump_target;
      end else if (dec_branch && br_taken) begin
        pc_q <= branch_target;
      end else begin
        pc_q <= pc_q + LEN_WORD'(4);
      end
    end
  end

  assign pc    = pc_q;
  assign state = state_q;

`ifdef CORE_PERF_CNT_EN
  logic [63:0] cycle_q;
  logic [63:0] retire_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      if (state_q != S_HALT) cycle_q  <= cycle_q + 64'd1;
      if (state_q == S_WB)   retire_q <= retire_q + 64'd1;
    end
  end

  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
`endif

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM for the single-issue core. It sequences fetch, decode, execute, memory and writeback around the instruction decoder and ALU.
- Owns the PC register and the instruction-register capture strobe. Drives the instruction/data memory handshakes and the register-file write enable.
- Consumes the decoder's instruction-class flags and the resolved jump/branch targets.

Parameters:
- LEN_WORD, 32, datapath/PC width
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  core clock
- rst  in  1  reset: synchronous, active-high; one clock (`clk`), all state updates on its rising edge
- pc  out  LEN_WORD  current PC, fed to imem address and decoder pc input
- imem_req  out  1  instruction fetch request
- imem_valid  in  1  instruction word valid this cycle
- inst_we  out  1  capture strobe for the instruction register
- dec_alu  in  1  decoder class flag, ALU / ALU-immediate
- dec_mem  in  1  decoder class flag, load/store
- dec_mem_store  in  1  1 = store (OP_MEMS), 0 = load; valid when dec_mem
- dec_jump  in  1  decoder class flag, JAL/JALR
- dec_branch  in  1  decoder class flag, conditional branch
- dec_subst  in  1  decoder class flag, LUI/AUIPC
- br_taken  in  1  ALU branch comparison result; valid in EXEC and WB
- jump_target  in  LEN_WORD  jump destination (decoder d_rs1)
- branch_target  in  LEN_WORD  branch destination (decoder d_rs3)
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable
- dmem_done  in  1  data access complete
- rf_we  out  1  register-file write enable
- halted  out  1  core stopped on an undecodable instruction
- state  out  3  FSM state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. Values 5 and 6 are unreachable; if entered, go to HALT.
- Reset: rst sampled high →
  - state=FETCH, pc=RESET_PC
  - next cycle: imem_req=1; all other strobes 0; halted=0
  - rst overrides every transition, including mid-MEM. The in-flight access is abandoned.
  - A late dmem_done/imem_valid arriving after reset is ignored outside its waiting state.
- FETCH:
  - imem_req=1.
  - When imem_valid=1: inst_we=1 in the same cycle (combinational from state & imem_valid), next state DECODE.
  - Otherwise stay in FETCH; no timeout.
- DECODE: one cycle for register-file read.
  - No class flag asserted (dec_alu|dec_mem|dec_jump|dec_branch|dec_subst == 0) → HALT.
  - Otherwise → EXEC.
- EXEC: one cycle. dec_mem → MEM, else → WB.
- MEM:
  - dmem_req=1, dmem_we=dec_mem_store; both held stable until dmem_done.
  - On dmem_done → WB. dmem_done in the same cycle as MEM entry is accepted.
- WB: one cycle, then → FETCH.
  - rf_we=1 iff dec_alu | dec_subst | dec_jump | (dec_mem & ~dec_mem_store).
  - PC update, registered at end of WB, priority order:
    - dec_jump → jump_target
    - dec_branch & br_taken → branch_target
    - otherwise pc + 4, wrapping modulo 2^LEN_WORD (0xFFFF_FFFC → 0)
- HALT:
  - halted=1; all strobes 0; pc frozen at the offending instruction.
  - Exit only via rst.
- Strobe/state coupling: imem_req, dmem_req, dmem_we, rf_we and halted are decoded from state only. Exception: dmem_we additionally depends on dec_mem_store.
- imem_valid outside FETCH and dmem_done outside MEM are ignored.
- Latency with zero-wait memories:
  - ALU/branch/jump: 4 cycles per instruction (FETCH, DECODE, EXEC, WB)
  - load/store: 5 cycles, plus one per memory wait cycle

Optional Feature:
- Macro: CORE_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[63:0] and retire_cnt[63:0], both reset to 0.
  - cycle_cnt increments every cycle except in HALT.
  - retire_cnt increments once per WB cycle.
  - Both wrap at 2^64.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset then ADDI, imem_valid same cycle as request, dmem idle → state sequence 0,1,2,4,0; rf_we=1 in exactly one cycle; pc 0→4 after WB.
- Load with dmem_done delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0; rf_we=1 in WB; 8 cycles total.
- Store → dmem_we=1 throughout MEM; rf_we=0; pc+4.
- Branch at pc=0x10 with branch_target=0x40:
  - br_taken=1 → next pc 0x40
  - br_taken=0 → next pc 0x14
  - JAL with jump_target=0x100 and dec_branch also forced high → pc=0x100, rf_we=1.
- All class flags 0 at pc=0x20 → HALT; halted=1; pc stays 0x20; imem_valid pulses ignored; rst → pc=RESET_PC, state FETCH.
- rst asserted in MEM while dmem_done=0, then dmem_done pulses after reset → no rf_we; fetch restarts at RESET_PC.
  - With CORE_PERF_CNT_EN defined: retire_cnt=0 after reset; counts 1 after the next WB.
